// File: rtl/busctrl_reg_pkg.sv
// -----------------------------------------------------------------------------
// busctrl_reg_pkg
// Shared types and constants for the CPU-to-slave bus controller.
//   - bc_state_e : controller FSM encoding (IDLE=0, ACCESS=1, DONE=2)
//   - standard address map: RAM, ROM and a row of 1 MiB I/O slots
//   - std_map_base()/std_map_mask(): flattened 8-slave standard map
//     (slave 0 = RAM, slave 1 = ROM, slaves 2..7 = I/O slots 0..5)
// Optional feature macro used by the controller: BUSCTRL_TMO_EN.
// -----------------------------------------------------------------------------
package busctrl_reg_pkg;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAccess = 2'd1,
        StDone   = 2'd2
    } bc_state_e;

    localparam logic [31:0] RamBase  = 32'h0000_0000;
    localparam logic [31:0] RamMask  = 32'hFE00_0000;
    localparam logic [31:0] RomBase  = 32'h2000_0000;
    localparam logic [31:0] RomMask  = 32'hFFE0_0000;
    localparam logic [31:0] IoBase0  = 32'h3000_0000;
    localparam logic [31:0] IoStride = 32'h0010_0000;
    localparam logic [31:0] IoMask   = 32'hFFF0_0000;

    localparam int unsigned StdNumSlv = 8;

    // Base address of I/O slot n.
    function automatic logic [31:0] io_base(input int unsigned n);
        return IoBase0 + (IoStride * 32'(n));
    endfunction

    function automatic logic [StdNumSlv*32-1:0] std_map_base();
        logic [StdNumSlv*32-1:0] m;
        m          = '0;
        m[0 +: 32]  = RamBase;
        m[32 +: 32] = RomBase;
        for (int unsigned n = 0; n < StdNumSlv - 2; n++) begin
            m[32*(n+2) +: 32] = io_base(n);
        end
        return m;
    endfunction

    function automatic logic [StdNumSlv*32-1:0] std_map_mask();
        logic [StdNumSlv*32-1:0] m;
        m          = '0;
        m[0 +: 32]  = RamMask;
        m[32 +: 32] = RomMask;
        for (int unsigned n = 0; n < StdNumSlv - 2; n++) begin
            m[32*(n+2) +: 32] = IoMask;
        end
        return m;
    endfunction

    localparam logic [StdNumSlv*32-1:0] StdBase = std_map_base();
    localparam logic [StdNumSlv*32-1:0] StdMask = std_map_mask();

endpackage

// File: rtl/busctrl_dec.sv
// -----------------------------------------------------------------------------
// busctrl_dec
// Combinational address decoder. Slave i hits when (addr & MASK_i) == BASE_i;
// when several slaves hit, the lowest index wins.
// Ports:
//   addr_i : byte address to decode
//   sel_o  : one-hot slave select (all zero when nothing hits)
//   hit_o  : at least one slave matched
// -----------------------------------------------------------------------------
module busctrl_dec #(
    parameter int unsigned           NUM_SLV  = 8,
    parameter logic [32*NUM_SLV-1:0] SLV_BASE = '0,
    parameter logic [32*NUM_SLV-1:0] SLV_MASK = '0
) (
    input  logic [31:0]        addr_i,
    output logic [NUM_SLV-1:0] sel_o,
    output logic               hit_o
);

    // Scan from the top down so a lower-index match overwrites a higher one.
    always_comb begin
        sel_o = '0;
        hit_o = 1'b0;
        for (int i = int'(NUM_SLV) - 1; i >= 0; i--) begin
            if ((addr_i & SLV_MASK[32*i +: 32]) == SLV_BASE[32*i +: 32]) begin
                sel_o    = '0;
                sel_o[i] = 1'b1;
                hit_o    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/busctrl_reg.sv
// -----------------------------------------------------------------------------
// busctrl_reg
// Registered bus controller between the CPU bus and NUM_SLV slaves. A request
// is latched in IDLE, decoded against the base/mask map, and forwarded to one
// slave in ACCESS until that slave drops its wait. DONE presents read data and
// bus error to the CPU for exactly one cycle.
// Ports:
//   clk, reset_n           : clock, asynchronous active-low reset
//   cpu_en/wr/size/addr    : CPU request (sampled in IDLE only)
//   cpu_data_out           : CPU write data
//   cpu_data_in, cpu_berr  : read data / bus error, valid while cpu_wt = 0
//   cpu_wt                 : CPU must wait
//   slv_en                 : one-hot slave enable, high during ACCESS
//   slv_wr/size/addr/wdata : latched request fields
//   slv_rdata, slv_wt      : flattened per-slave read data and wait
// Optional feature macro: BUSCTRL_TMO_EN -- abort an ACCESS that lasts
// TMO_CYCLES cycles with a bus error. Without it ACCESS waits indefinitely.
// -----------------------------------------------------------------------------
module busctrl_reg
    import busctrl_reg_pkg::*;
#(
    parameter int unsigned           NUM_SLV    = 8,
    parameter logic [32*NUM_SLV-1:0] SLV_BASE   = '0,
    parameter logic [32*NUM_SLV-1:0] SLV_MASK   = '0,
    parameter int unsigned           TMO_CYCLES = 255,
    parameter int unsigned           TMO_W      = 8
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   cpu_en,
    input  logic                   cpu_wr,
    input  logic [1:0]             cpu_size,
    input  logic [31:0]            cpu_addr,
    input  logic [31:0]            cpu_data_out,
    output logic [31:0]            cpu_data_in,
    output logic                   cpu_wt,
    output logic                   cpu_berr,
    output logic [NUM_SLV-1:0]     slv_en,
    output logic                   slv_wr,
    output logic [1:0]             slv_size,
    output logic [31:0]            slv_addr,
    output logic [31:0]            slv_wdata,
    input  logic [32*NUM_SLV-1:0]  slv_rdata,
    input  logic [NUM_SLV-1:0]     slv_wt
);

    bc_state_e          state_q;
    logic [NUM_SLV-1:0] sel_q;
    logic [NUM_SLV-1:0] slv_en_q;
    logic               wr_q;
    logic [1:0]         size_q;
    logic [31:0]        addr_q;
    logic [31:0]        wdata_q;
    logic [31:0]        rdata_q;
    logic               berr_q;
    logic               wt_q;

    logic [NUM_SLV-1:0] dec_sel;
    logic               dec_hit;
    logic               sel_wt;
    logic [31:0]        sel_rdata;

    busctrl_dec #(
        .NUM_SLV  (NUM_SLV),
        .SLV_BASE (SLV_BASE),
        .SLV_MASK (SLV_MASK)
    ) u_dec (
        .addr_i (cpu_addr),
        .sel_o  (dec_sel),
        .hit_o  (dec_hit)
    );

    // AND-OR mux on the latched one-hot select; unselected slaves contribute nothing.
    always_comb begin
        sel_wt    = |(slv_wt & sel_q);
        sel_rdata = '0;
        for (int i = 0; i < int'(NUM_SLV); i++) begin
            if (sel_q[i]) begin
                sel_rdata = sel_rdata | slv_rdata[32*i +: 32];
            end
        end
    end

`ifdef BUSCTRL_TMO_EN
    localparam logic [TMO_W-1:0] TmoLimit = TMO_W'(TMO_CYCLES);

    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;
    logic             tmo_hit;

    // cnt_d counts ACCESS cycles including the current one; saturates at all-ones.
    always_comb begin
        cnt_d   = (cnt_q == {TMO_W{1'b1}}) ? cnt_q : cnt_q + TMO_W'(1);
        tmo_hit = (cnt_d >= TmoLimit);
    end
`else
    // Timeout parameters only shape the timeout build.
    if (TMO_CYCLES == 0 || TMO_W == 0) begin : g_tmo_cfg_unused
    end
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= StIdle;
            sel_q    <= '0;
            slv_en_q <= '0;
            wr_q     <= 1'b0;
            size_q   <= 2'd0;
            addr_q   <= 32'd0;
            wdata_q  <= 32'd0;
            rdata_q  <= 32'd0;
            berr_q   <= 1'b0;
            wt_q     <= 1'b1;
`ifdef BUSCTRL_TMO_EN
            cnt_q    <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (cpu_en) begin
                        wr_q    <= cpu_wr;
                        size_q  <= cpu_size;
                        addr_q  <= cpu_addr;
                        wdata_q <= cpu_data_out;
                        sel_q   <= dec_sel;
                        if (dec_hit) begin
                            state_q  <= StAccess;
                            slv_en_q <= dec_sel;
`ifdef BUSCTRL_TMO_EN
                            cnt_q    <= '0;
`endif
                        end else begin
                            // Unmapped: straight to DONE with an error, no slave touched.
                            state_q <= StDone;
                            berr_q  <= 1'b1;
                            rdata_q <= 32'd0;
                            wt_q    <= 1'b0;
                        end
                    end
                end
                StAccess: begin
`ifdef BUSCTRL_TMO_EN
                    cnt_q <= cnt_d;
`endif
                    if (!sel_wt) begin
                        state_q  <= StDone;
                        slv_en_q <= '0;
                        rdata_q  <= sel_rdata;
                        berr_q   <= 1'b0;
                        wt_q     <= 1'b0;
                    end
`ifdef BUSCTRL_TMO_EN
                    else if (tmo_hit) begin
                        state_q  <= StDone;
                        slv_en_q <= '0;
                        rdata_q  <= 32'd0;
                        berr_q   <= 1'b1;
                        wt_q     <= 1'b0;
                    end
`endif
                end
                StDone: begin
                    state_q <= StIdle;
                    wt_q    <= 1'b1;
                end
                default: begin
                    state_q  <= StIdle;
                    slv_en_q <= '0;
                    wt_q     <= 1'b1;
                end
            endcase
        end
    end

    assign cpu_data_in = rdata_q;
    assign cpu_wt      = wt_q;
    assign cpu_berr    = berr_q;
    assign slv_en      = slv_en_q;
    assign slv_wr      = wr_q;
    assign slv_size    = size_q;
    assign slv_addr    = addr_q;
    assign slv_wdata   = wdata_q;

endmodule
